// File: rtl/prio_sel_pkg.sv
// Package: prio_sel_pkg
//
// Shared types and helpers for the prioritised select mux pipeline.
//   sel_mode_e : arbitration mode (fixed priority or round-robin)
//   next_idx   : modulo increment of a channel index, wrapping at n
package prio_sel_pkg;

  typedef enum logic {
    SEL_FIXED = 1'b0,
    SEL_RR    = 1'b1
  } sel_mode_e;

  // Channel index after idx, wrapping to 0 past the last channel. Works for
  // any n, not just powers of two.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/prio_sel_arbiter.sv
// Module: prio_sel_arbiter
//
// One-hot arbiter over N_IN requesters, fixed priority or round-robin.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset (clears rr_ptr)
//   req      in   per-channel request
//   enable   in   arbitrate this cycle; no grant when low
//   mode     in   SEL_FIXED: lowest index wins; SEL_RR: first at/after rr_ptr
//   gnt      out  one-hot grant, or zero
//   gnt_idx  out  index of the granted channel (0 when no grant)
module prio_sel_arbiter
  import prio_sel_pkg::*;
#(
  parameter int unsigned N_IN  = 8,
  parameter int unsigned IDX_W = $clog2(N_IN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IN-1:0]  req,
  input  logic             enable,
  input  sel_mode_e        mode,
  output logic [N_IN-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] cand;
  logic             found;
  int unsigned      pos;

  // Scan channels starting at the base (0 in fixed mode, rr_ptr in RR mode),
  // folding the position back into [0, N_IN) so the pointer never leaves range.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = 0;
    cand    = '0;
    if (enable) begin
      for (int unsigned k = 0; k < N_IN; k++) begin
        pos = (mode == SEL_RR) ? 32'(rr_ptr_q) + k : k;
        if (pos >= N_IN) begin
          pos = pos - N_IN;
        end
        cand = IDX_W'(pos);
        if (!found && req[cand]) begin
          found     = 1'b1;
          gnt[cand] = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
  end

  // The pointer only advances on an actual grant; it moves past the winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else if (found) begin
      rr_ptr_q <= IDX_W'(next_idx(32'(gnt_idx), N_IN));
    end
  end

endmodule

// File: rtl/prio_sel_mux_pipe.sv
// Module: prio_sel_mux_pipe
//
// N-way select mux with per-channel valid/ready inputs, an arbiter choosing one
// channel per cycle, and a one-entry registered output stage.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   in_valid   in   per-channel request
//   in_data    in   channel i at bits [i*WIDTH +: WIDTH]
//   in_ready   out  one-hot or zero: accept for the granted channel
//   out_valid  out  output stage holds a word
//   out_data   out  selected word
//   out_idx    out  channel that supplied out_data
//   out_ready  in   downstream accept
module prio_sel_mux_pipe
  import prio_sel_pkg::*;
#(
  parameter int unsigned  WIDTH    = 11,
  parameter int unsigned  N_IN     = 8,
  parameter int unsigned  SEL_MODE = 0,
  localparam int unsigned IDX_W    = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_IN-1:0]       in_valid,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic [N_IN-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDX_W-1:0]      out_idx,
  input  logic                  out_ready
);

  localparam sel_mode_e Mode = (SEL_MODE == 1) ? SEL_RR : SEL_FIXED;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [IDX_W-1:0] out_idx_q;

  logic             stage_open;
  logic             arb_en;
  logic [N_IN-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic [WIDTH-1:0] sel_data;

  assign stage_open = !out_valid_q || out_ready;
  // Gating with reset keeps in_ready low in reset cycles, so no transfer completes.
  assign arb_en     = stage_open && !reset;

  prio_sel_arbiter #(
    .N_IN  (N_IN),
    .IDX_W (IDX_W)
  ) u_arbiter (
    .clk     (clk),
    .reset   (reset),
    .req     (in_valid),
    .enable  (arb_en),
    .mode    (Mode),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign in_ready = gnt;

  // One-hot select: only the granted slice reaches sel_data, so X on other
  // channels cannot leak into the output.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (gnt[i]) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // A new grant overwrites a draining word in the same cycle (no bubble);
  // a drain without a grant clears valid but keeps the last data/index.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
    end else if (stage_open) begin
      if (|gnt) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sel_data;
        out_idx_q   <= gnt_idx;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_prio_sel_mux_pipe.sv
module tb_prio_sel_mux_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // A: fixed priority, 8 x 11
  logic [7:0]  a_valid, a_ready;
  logic [87:0] a_data;
  logic        a_ov, a_or;
  logic [10:0] a_od;
  logic [2:0]  a_oi;
  // B: round-robin, 8 x 11
  logic [7:0]  b_valid, b_ready;
  logic [87:0] b_data;
  logic        b_ov, b_or;
  logic [10:0] b_od;
  logic [2:0]  b_oi;
  // C: round-robin, 5 x 3 (random regression)
  logic [4:0]  c_valid, c_ready;
  logic [14:0] c_data;
  logic        c_ov, c_or;
  logic [2:0]  c_od;
  logic [2:0]  c_oi;

  prio_sel_mux_pipe #(.WIDTH(11), .N_IN(8), .SEL_MODE(0)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_valid), .in_data(a_data), .in_ready(a_ready),
    .out_valid(a_ov), .out_data(a_od), .out_idx(a_oi), .out_ready(a_or)
  );
  prio_sel_mux_pipe #(.WIDTH(11), .N_IN(8), .SEL_MODE(1)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_valid), .in_data(b_data), .in_ready(b_ready),
    .out_valid(b_ov), .out_data(b_od), .out_idx(b_oi), .out_ready(b_or)
  );
  prio_sel_mux_pipe #(.WIDTH(3), .N_IN(5), .SEL_MODE(1)) dut_c (
    .clk(clk), .reset(reset), .in_valid(c_valid), .in_data(c_data), .in_ready(c_ready),
    .out_valid(c_ov), .out_data(c_od), .out_idx(c_oi), .out_ready(c_or)
  );

  typedef struct {
    logic [7:0]  iv;
    logic        ordy;
    logic [7:0]  e_rdy;
    logic        e_ov;
    logic [2:0]  e_oi;
    logic [10:0] e_od;
  } vec_t;

  typedef struct packed {
    logic [2:0] idx;
    logic [2:0] dat;
  } sb_t;

  vec_t tbl[11];
  sb_t  sbq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   rr_m;
    int   g;
    int   p;
    bit   open;
    sb_t  e;
    logic [4:0] e_rdy;

    // iv, out_ready, exp in_ready, exp out_valid, exp out_idx, exp out_data
    tbl[0]  = '{8'h24, 1'b1, 8'h04, 1'b0, 3'd0, 11'h000};
    tbl[1]  = '{8'h20, 1'b1, 8'h20, 1'b1, 3'd2, 11'h0A2};
    tbl[2]  = '{8'h00, 1'b1, 8'h00, 1'b1, 3'd5, 11'h0A5};
    tbl[3]  = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd5, 11'h0A5};
    tbl[4]  = '{8'hFF, 1'b0, 8'h01, 1'b0, 3'd5, 11'h0A5};
    tbl[5]  = '{8'hFF, 1'b0, 8'h00, 1'b1, 3'd0, 11'h0A0};
    tbl[6]  = '{8'h80, 1'b1, 8'h80, 1'b1, 3'd0, 11'h0A0};
    tbl[7]  = '{8'hC0, 1'b1, 8'h40, 1'b1, 3'd7, 11'h0A7};
    tbl[8]  = '{8'h00, 1'b0, 8'h00, 1'b1, 3'd6, 11'h0A6};
    tbl[9]  = '{8'h00, 1'b1, 8'h00, 1'b1, 3'd6, 11'h0A6};
    tbl[10] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd6, 11'h0A6};

    for (int i = 0; i < 8; i++) begin
      a_data[i*11 +: 11] = 11'h0A0 + 11'(i);
      b_data[i*11 +: 11] = 11'h2A0 + 11'(i);
    end
    a_data[3*11 +: 11] = 'x;  // channel 3 never wins; its X must not leak
    c_data = '0;

    // Reset with every channel requesting
    reset = 1'b1;
    a_valid = 8'hFF; b_valid = 8'hFF; c_valid = 5'h1F;
    a_or = 1'b0; b_or = 1'b0; c_or = 1'b0;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk("rst_a_ready", 32'(a_ready), 32'h0);
      chk("rst_b_ready", 32'(b_ready), 32'h0);
      chk("rst_c_ready", 32'(c_ready), 32'h0);
      next_cyc();
    end
    chk("rst_a_ov", 32'(a_ov), 32'h0);
    chk("rst_a_od", 32'(a_od), 32'h0);
    chk("rst_a_oi", 32'(a_oi), 32'h0);
    chk("rst_b_ov", 32'(b_ov), 32'h0);
    chk("rst_c_ov", 32'(c_ov), 32'h0);
    reset = 1'b0;
    b_valid = 8'h00; c_valid = 5'h00;

    // Fixed-priority vector table
    for (int i = 0; i < 11; i++) begin
      a_valid = tbl[i].iv;
      a_or    = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("fix%0d_ready", i), 32'(a_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("fix%0d_ov", i), 32'(a_ov), 32'(tbl[i].e_ov));
      chk($sformatf("fix%0d_oi", i), 32'(a_oi), 32'(tbl[i].e_oi));
      chk($sformatf("fix%0d_od", i), 32'(a_od), 32'(tbl[i].e_od));
      next_cyc();
    end
    a_valid = 8'h00;

    // Round-robin sweep: all valid, out_ready high
    b_valid = 8'hFF; b_or = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_ready", j), 32'(b_ready), 32'(1) << (j % 8));
      if (j == 0) begin
        chk("rr0_ov", 32'(b_ov), 32'h0);
      end else begin
        chk($sformatf("rr%0d_ov", j), 32'(b_ov), 32'h1);
        chk($sformatf("rr%0d_oi", j), 32'(b_oi), 32'((j - 1) % 8));
        chk($sformatf("rr%0d_od", j), 32'(b_od), 32'h2A0 + 32'((j - 1) % 8));
      end
      next_cyc();
    end

    // Backpressure holding 11'h2A5; rr_ptr must stay at 6
    b_valid = 8'h20;
    @(negedge clk);
    chk("bp_load_ready", 32'(b_ready), 32'h20);
    next_cyc();
    b_valid = 8'hFF; b_or = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_ready", j), 32'(b_ready), 32'h0);
      chk($sformatf("bp%0d_ov", j), 32'(b_ov), 32'h1);
      chk($sformatf("bp%0d_od", j), 32'(b_od), 32'h2A5);
      chk($sformatf("bp%0d_oi", j), 32'(b_oi), 32'h5);
      next_cyc();
    end
    b_or = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(b_ready), 32'h40);
    next_cyc();

    // Reset while holding a word under backpressure
    b_or = 1'b0; b_valid = 8'h00;
    @(negedge clk);
    chk("rst6_pre_ov", 32'(b_ov), 32'h1);
    chk("rst6_pre_oi", 32'(b_oi), 32'h6);
    next_cyc();
    reset = 1'b1; b_valid = 8'hFF;
    @(negedge clk);
    chk("rst6_ready", 32'(b_ready), 32'h0);
    next_cyc();
    reset = 1'b0; b_or = 1'b1;
    @(negedge clk);
    chk("rst6_ov", 32'(b_ov), 32'h0);
    chk("rst6_ready_ch0", 32'(b_ready), 32'h01);
    next_cyc();
    b_valid = 8'h00;
    next_cyc();
    next_cyc();

    // Random regression on the 5-channel instance; C has been idle since reset
    rr_m = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      c_valid = 5'($urandom);
      c_data  = 15'($urandom);
      c_or    = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      open = (sbq.size() == 0) || c_or;
      chk("rnd_ov", 32'(c_ov), 32'(sbq.size() != 0));
      if (sbq.size() != 0 && c_or) begin
        e = sbq.pop_front();
        chk("rnd_oi", 32'(c_oi), 32'(e.idx));
        chk("rnd_od", 32'(c_od), 32'(e.dat));
      end
      g = -1;
      if (open) begin
        for (int k = 0; k < 5; k++) begin
          p = (rr_m + k) % 5;
          if (g < 0 && c_valid[p]) g = p;
        end
      end
      e_rdy = (g >= 0) ? 5'(1 << g) : 5'h0;
      chk("rnd_ready", 32'(c_ready), 32'(e_rdy));
      if (g >= 0) begin
        e.idx = 3'(g);
        e.dat = c_data[g*3 +: 3];
        sbq.push_back(e);
        rr_m = (g == 4) ? 0 : g + 1;
      end
      next_cyc();
    end
    c_valid = 5'h00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
